// File: rtl/fpu_div.sv
// ---------------------------------------------------------------------------
// fpu_div -- iterative single-precision floating-point divider
//
// Radix-2 restoring divider. Subnormal operands are pre-normalised first.
// The result is a 35-bit unrounded intermediate that goes to the shared FPU
// rounding/packing logic.
//
// Optional build macro: FPU_DIV_EARLY_TERM_EN
//   defined   : DIV stops at the first step whose updated remainder is zero
//               (the result is bit-identical, latency varies)
//   undefined : DIV always runs all 27 quotient steps
//
// Ports
//   clk                  clock
//   rst                  synchronous active-high reset
//   opa, opb [31:0]      dividend / divisor (IEEE-754 single), taken on new_input
//   new_input            start pulse; also aborts an operation in progress
//   subn_fl_a/b          operand is subnormal
//   z_fl_a/b             operand is +-0
//   inf_fl_a/b           operand is +-inf
//   nan_fl               either operand is NaN
//   out [34:0]           {sign, exp[7:0], frac[22:0], G, R, S}, registered
//   busy                 new_input OR unit not idle
// ---------------------------------------------------------------------------
module fpu_div (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        new_input,
   input  logic        subn_fl_a,
   input  logic        subn_fl_b,
   input  logic        z_fl_a,
   input  logic        z_fl_b,
   input  logic        inf_fl_a,
   input  logic        inf_fl_b,
   input  logic        nan_fl,
   output logic [34:0] out,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NORM = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [4:0] LAST_STEP = 5'd26;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t      r_state;
   logic        r_sign;
   logic [23:0] r_ma;      // dividend mantissa (used while normalising)
   logic [23:0] r_mb;      // divisor mantissa
   logic [9:0]  r_exp;     // signed working exponent
   logic [24:0] r_rem;     // partial remainder
   logic [25:0] r_q;       // quotient bits collected so far
   logic [4:0]  r_step;    // DIV step index, 0..26
   logic [34:0] r_out;

   assign out  = r_out;
   assign busy = new_input | (r_state != S_IDLE);

   // ------------------------------------------------------------------
   // Capture-side decode
   // ------------------------------------------------------------------
   logic [23:0] w_ma_cap;
   logic [23:0] w_mb_cap;
   logic [7:0]  w_ea_cap;
   logic [7:0]  w_eb_cap;
   logic [9:0]  w_exp_cap;
   logic        w_sign_cap;
   logic        w_special;
   logic [34:0] w_special_out;

   // A subnormal has no hidden bit and behaves as if its exponent field were 1.
   assign w_ma_cap   = {~subn_fl_a, opa[22:0]};
   assign w_mb_cap   = {~subn_fl_b, opb[22:0]};
   assign w_ea_cap   = subn_fl_a ? 8'd1 : opa[30:23];
   assign w_eb_cap   = subn_fl_b ? 8'd1 : opb[30:23];
   assign w_exp_cap  = {2'b00, w_ea_cap} - {2'b00, w_eb_cap} + 10'd127;
   assign w_sign_cap = opa[31] ^ opb[31];

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else chain can leave it unassigned and infer a latch.
   always_comb begin
      w_special     = 1'b1;
      w_special_out = '0;
      if (nan_fl) begin
         // Propagate the NaN-side operand: the one with the larger magnitude.
         if (opa[30:0] >= opb[30:0])
            w_special_out = {opa, 3'b000};
         else
            w_special_out = {opb, 3'b000};
      end else if ((z_fl_a & z_fl_b) | (inf_fl_a & inf_fl_b)) begin
         w_special_out = {1'b0, 9'h1ff, 22'h1, 3'b000};
      end else if (z_fl_b | inf_fl_a) begin
         w_special_out = {w_sign_cap, 8'hff, 26'h0};
      end else if (z_fl_a | inf_fl_b) begin
         w_special_out = {w_sign_cap, 34'h0};
      end else begin
         w_special = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Pre-normalisation step
   // ------------------------------------------------------------------
   logic [23:0] w_ma_sh;
   logic [23:0] w_mb_sh;
   logic [9:0]  w_exp_norm;
   logic        w_norm_done;

   assign w_ma_sh     = r_ma[23] ? r_ma : {r_ma[22:0], 1'b0};
   assign w_mb_sh     = r_mb[23] ? r_mb : {r_mb[22:0], 1'b0};
   // Shifting the divisor up makes the quotient smaller, so e rises; the
   // dividend shift works the other way.
   assign w_exp_norm  = r_exp + {9'd0, ~r_mb[23]} - {9'd0, ~r_ma[23]};
   assign w_norm_done = w_ma_sh[23] & w_mb_sh[23];

   // ------------------------------------------------------------------
   // Restoring division step
   // ------------------------------------------------------------------
   logic        w_qbit;
   logic [24:0] w_diff;
   logic [24:0] w_rem_sel;
   logic [24:0] w_rem_next;
   logic [26:0] w_q_next;
   logic [26:0] w_q_fin;
   logic        w_div_done;

   assign w_qbit     = (r_rem >= {1'b0, r_mb});
   assign w_diff     = r_rem - {1'b0, r_mb};
   assign w_rem_sel  = w_qbit ? w_diff : r_rem;
   // After a restoring step the remainder is below mb < 2^24, so the bit
   // dropped by this shift is always zero.
   assign w_rem_next = {w_rem_sel[23:0], 1'b0};
   assign w_q_next   = {r_q, w_qbit};

`ifdef FPU_DIV_EARLY_TERM_EN
   // Exact quotient found: all remaining quotient bits are zero, so align
   // the bits found so far as if the remaining steps had run.
   assign w_div_done = (r_step == LAST_STEP) || (w_rem_next == 25'd0);
   assign w_q_fin    = w_q_next << (LAST_STEP - r_step);
`else
   assign w_div_done = (r_step == LAST_STEP);
   assign w_q_fin    = w_q_next;
`endif

   // ------------------------------------------------------------------
   // Finish: align quotient, handle range limits, build the intermediate
   // ------------------------------------------------------------------
   logic [25:0] w_sig;
   logic        w_stk;
   logic [9:0]  w_exp_fin;
   logic [9:0]  w_shamt;
   logic [50:0] w_wide;
   logic [34:0] w_fin_out;

   always_comb begin
      if (w_q_fin[26]) begin
         w_sig     = w_q_fin[26:1];
         w_stk     = w_q_fin[0] | (w_rem_next != 25'd0);
         w_exp_fin = r_exp;
      end else begin
         w_sig     = w_q_fin[25:0];
         w_stk     = (w_rem_next != 25'd0);
         w_exp_fin = r_exp - 10'd1;
      end

      // Denormalising shift by (1 - e). The pre-shifted base {sig, 25'b0}
      // already carries one position, so the variable shift is just -e.
      // Bits [50:26] are the surviving significand minus its (now zero)
      // hidden position, bits [25:0] are what fell off into the sticky.
      w_shamt = 10'd0 - w_exp_fin;
      w_wide  = {w_sig, 25'd0} >> w_shamt;

      if ($signed(w_exp_fin) > 10'sd254)
         w_fin_out = {r_sign, 8'hff, 26'h0};
      else if ($signed(w_exp_fin) < -10'sd25)
         w_fin_out = {r_sign, 8'h00, 25'h0, 1'b1};
      else if ($signed(w_exp_fin) < 10'sd1)
         w_fin_out = {r_sign, 8'h00, w_wide[50:26], w_stk | (w_wide[25:0] != 26'd0)};
      else
         w_fin_out = {r_sign, w_exp_fin[7:0], w_sig[24:0], w_stk};
   end

   // ------------------------------------------------------------------
   // Control FSM and datapath registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath is small, so every register (not just the
         // state) is cleared; out is then defined as zero after reset.
         r_state <= S_IDLE;
         r_sign  <= 1'b0;
         r_ma    <= '0;
         r_mb    <= '0;
         r_exp   <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_step  <= '0;
         r_out   <= '0;
      end else if (new_input) begin
         // Capture wins in every state, aborting any operation in flight.
         r_sign <= w_sign_cap;
         if (w_special) begin
            r_out   <= w_special_out;
            r_state <= S_IDLE;
         end else begin
            r_ma    <= w_ma_cap;
            r_mb    <= w_mb_cap;
            r_exp   <= w_exp_cap;
            r_rem   <= {1'b0, w_ma_cap};
            r_q     <= '0;
            r_step  <= '0;
            r_state <= (w_ma_cap[23] & w_mb_cap[23]) ? S_DIV : S_NORM;
         end
      end else begin
         case (r_state)
            S_NORM: begin
               r_ma  <= w_ma_sh;
               r_mb  <= w_mb_sh;
               r_exp <= w_exp_norm;
               r_rem <= {1'b0, w_ma_sh};
               if (w_norm_done)
                  r_state <= S_DIV;
            end
            S_DIV: begin
               r_rem  <= w_rem_next;
               r_q    <= w_q_next[25:0];
               r_step <= r_step + 5'd1;
               if (w_div_done) begin
                  r_out   <= w_fin_out;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_div.sv
// ---------------------------------------------------------------------------
// tb_fpu_div -- directed self-checking bench for fpu_div
//
// Each vector is driven with operand flags decoded here from the IEEE bits;
// the result and the number of cycles busy stays high are compared against
// hand-computed values. Latency expectations follow FPU_DIV_EARLY_TERM_EN.
// ---------------------------------------------------------------------------
module tb_fpu_div;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        new_input;
   logic        subn_fl_a, subn_fl_b;
   logic        z_fl_a, z_fl_b;
   logic        inf_fl_a, inf_fl_b;
   logic        nan_fl;
   logic [34:0] out;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   fpu_div dut (
      .clk       (clk),
      .rst       (rst),
      .opa       (opa),
      .opb       (opb),
      .new_input (new_input),
      .subn_fl_a (subn_fl_a),
      .subn_fl_b (subn_fl_b),
      .z_fl_a    (z_fl_a),
      .z_fl_b    (z_fl_b),
      .inf_fl_a  (inf_fl_a),
      .inf_fl_b  (inf_fl_b),
      .nan_fl    (nan_fl),
      .out       (out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected busy cycles: cycle 0, NORM cycles, then either every DIV step
   // or only the steps up to the exact-remainder step.
   function automatic int lat(input int norm_cyc, input int exact_steps);
`ifdef FPU_DIV_EARLY_TERM_EN
      return 1 + norm_cyc + exact_steps;
`else
      return 1 + norm_cyc + 27 + (exact_steps - exact_steps);
`endif
   endfunction

   // {subn, zero, inf, nan} decoded from the IEEE bit pattern.
   function automatic logic [3:0] decode(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] f;
      e = x[30:23];
      f = x[22:0];
      return {(e == 8'h00) && (f != 0), (e == 8'h00) && (f == 0),
              (e == 8'hff) && (f == 0), (e == 8'hff) && (f != 0)};
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b);
      logic [3:0] fa, fb;
      fa = decode(a);
      fb = decode(b);
      opa       = a;
      opb       = b;
      subn_fl_a = fa[3];
      subn_fl_b = fb[3];
      z_fl_a    = fa[2];
      z_fl_b    = fb[2];
      inf_fl_a  = fa[1];
      inf_fl_b  = fb[1];
      nan_fl    = fa[0] | fb[0];
      new_input = 1'b1;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [34:0] exp_out, input int exp_cyc);
      int n;
      @(negedge clk);
      drive(a, b);
      #1;
      n = busy ? 1 : 0;
      @(negedge clk);
      new_input = 1'b0;
      #1;
      while (busy && n < 300) begin
         n++;
         @(negedge clk);
         #1;
      end
      check({tag, "_out"}, 64'(out), 64'(exp_out));
      check({tag, "_busy"}, 64'(n), 64'(exp_cyc));
   endtask

   localparam logic [34:0] R_6_3 = {1'b0, 8'h80, 26'h0};
   localparam logic [34:0] R_1_3 = {1'b0, 8'h7D, 23'h2AAAAA, 3'b101};

   initial begin
      rst       = 1'b1;
      opa       = '0;
      opb       = '0;
      new_input = 1'b0;
      subn_fl_a = 1'b0; subn_fl_b = 1'b0;
      z_fl_a    = 1'b0; z_fl_b    = 1'b0;
      inf_fl_a  = 1'b0; inf_fl_b  = 1'b0;
      nan_fl    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out", 64'(out), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);

      // Main function
      run_op("div_6_3", 32'h40C00000, 32'h40400000, R_6_3, lat(0, 1));
      run_op("div_1_3", 32'h3F800000, 32'h40400000, R_1_3, lat(0, 27));

      // Special cases, resolved at capture
      run_op("sp_1_0",    32'h3F800000, 32'h00000000, {1'b0, 8'hff, 26'h0}, 1);
      run_op("sp_0_0",    32'h00000000, 32'h00000000, 35'h3FE000008, 1);
      run_op("sp_0_2",    32'h00000000, 32'h40000000, 35'h0, 1);
      run_op("sp_m0_2",   32'h80000000, 32'h40000000, {1'b1, 34'h0}, 1);
      run_op("sp_inf_inf",32'h7F800000, 32'hFF800000, 35'h3FE000008, 1);
      run_op("sp_2_inf",  32'h40000000, 32'h7F800000, 35'h0, 1);
      run_op("sp_minf_2", 32'hFF800000, 32'h40000000, {1'b1, 8'hff, 26'h0}, 1);
      run_op("sp_nan_a",  32'h7FC00001, 32'h3F800000, {32'h7FC00001, 3'b000}, 1);
      run_op("sp_nan_b",  32'h3F800000, 32'hFFC00000, {32'hFFC00000, 3'b000}, 1);

      // Range limits
      run_op("ovf",       32'hFF000000, 32'h3E800000, {1'b1, 8'hff, 26'h0}, lat(0, 1));
      run_op("subn_res",  32'h00800000, 32'h40000000, {1'b0, 8'h00, 23'h400000, 3'b000}, lat(0, 1));
      run_op("deep_unf",  32'h00800000, 32'h7F000000, {1'b0, 8'h00, 25'h0, 1'b1}, lat(0, 1));

      // Pre-normalisation of either operand
      run_op("subn_a",    32'h00000001, 32'h3F800000, {1'b0, 8'h00, 23'h000001, 3'b000}, lat(23, 1));
      run_op("subn_b_254",32'h3F800000, 32'h00400000, {1'b0, 8'hFE, 26'h0}, lat(1, 1));
      run_op("subn_b_ovf",32'h40000000, 32'h00400000, {1'b0, 8'hff, 26'h0}, lat(1, 1));

      // Restart in DIV step 10: only the second operation's result appears
      run_op("pre_abort", 32'h3F800000, 32'h40400000, R_1_3, lat(0, 27));
      @(negedge clk);
      drive(32'h40C00000, 32'h40400000);      // 6/3 so out changes
      @(negedge clk);
      new_input = 1'b0;
      repeat (30) @(negedge clk);
      @(negedge clk);
      drive(32'h3F800000, 32'h40400000);      // 1/3, to be aborted
      @(negedge clk);
      new_input = 1'b0;
      repeat (10) @(negedge clk);             // now in DIV step 10
      #1;
      check("abort_hold", 64'(out), 64'(R_6_3));
      opa = 32'h40C00000;
      opb = 32'h40400000;
      drive(32'h40C00000, 32'h40400000);
      @(negedge clk);
      new_input = 1'b0;
      #1;
      begin
         int n;
         n = 1;
         while (busy && n < 300) begin
            n++;
            @(negedge clk);
            #1;
         end
         check("abort_out", 64'(out), 64'(R_6_3));
         check("abort_busy", 64'(n), 64'(lat(0, 1)));
      end

      // Reset in the middle of DIV
      @(negedge clk);
      drive(32'h3F800000, 32'h40400000);
      @(negedge clk);
      new_input = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("mid_busy", 64'(busy), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out", 64'(out), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
